// File: rtl/cm0_core_mul_seq.sv
// cm0_core_mul_seq: MSB-first shift-add MULS sequencer for the small multiplier; optional CM0_MUL_SEQ_EARLY_TERM_EN
module cm0_core_mul_seq #(
  parameter int CBAW = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mul_start_i,
  input  logic        mul_kill_i,
  input  logic [31:0] gpr_rb_data_i,
  input  logic [31:0] gpr_ra_data_i,
  input  logic        mul_sel_i,
  output logic [4:0]  mul_imm_o,
  output logic        mul_en_o,
  output logic        mul_busy_o,
  output logic        mul_done_o,
  output logic [31:0] mul_res_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state;
  logic [31:0] acc;
  logic [31:0] opb;
  logic [4:0]  imm;
  logic [4:0]  start_imm;
`ifdef CM0_MUL_SEQ_EARLY_TERM_EN
  logic [4:0]  k;
  // start at the select for Ra's top set bit; Ra<=1 leaves k=0 so imm starts at 0
  always_comb begin
    k = 5'd0;
    for (int i = 1; i < 32; i++) if (gpr_ra_data_i[i]) k = 5'(i);
    start_imm = 5'd0 - k;
  end
`else
  logic unused_ra;
  assign unused_ra = ^gpr_ra_data_i;
  assign start_imm = 5'd1;
`endif
  // sequencer: accept, accumulate one multiplier bit per cycle, pulse done
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc   <= '0;
      opb   <= '0;
      imm   <= '0;
    end else if (mul_kill_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (mul_start_i) begin
          state <= RUN;
          opb   <= gpr_rb_data_i;
          acc   <= '0;
          imm   <= start_imm;
        end
        RUN: begin
          acc   <= (acc << 1) + (mul_sel_i ? opb : 32'd0);
          imm   <= imm + 5'd1;
          state <= (imm == 5'd0) ? DONE : RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign mul_en_o   = state == RUN;
  assign mul_imm_o  = mul_en_o ? imm : 5'd0;
  assign mul_busy_o = state != IDLE;
  assign mul_done_o = state == DONE;
  assign mul_res_o  = acc;
endmodule

// File: tb/tb_cm0_core_mul_seq.sv
// tb_cm0_core_mul_seq: directed checks of the MULS sequencer against a 32:1 multiplier-bit mux model
module tb_cm0_core_mul_seq;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic        kill = 0;
  logic [31:0] ra = 0;
  logic [31:0] rb = 0;
  logic        sel;
  logic [4:0]  imm;
  logic        en, busy, done;
  logic [31:0] res;
  int          checks = 0;
  int          errors = 0;

  cm0_core_mul_seq dut (
    .clk_i(clk), .rst_i(rst), .mul_start_i(start), .mul_kill_i(kill),
    .gpr_rb_data_i(rb), .gpr_ra_data_i(ra), .mul_sel_i(sel),
    .mul_imm_o(imm), .mul_en_o(en), .mul_busy_o(busy), .mul_done_o(done), .mul_res_o(res)
  );

  always #5 clk = ~clk;
  assign sel = en & ra[(imm == 5'd0) ? 0 : 32 - int'(imm)];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int msb(input logic [31:0] a);
    int k = 0;
    for (int i = 1; i < 32; i++) if (a[i]) k = i;
    return k;
  endfunction

  function automatic int lat_of(input logic [31:0] a);
`ifdef CM0_MUL_SEQ_EARLY_TERM_EN
    return msb(a) + 2;
`else
    return 33;
`endif
  endfunction

  function automatic logic [4:0] imm0_of(input logic [31:0] a);
`ifdef CM0_MUL_SEQ_EARLY_TERM_EN
    return 5'(32 - msb(a));
`else
    return 5'd1;
`endif
  endfunction

  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    ra = a;
    rb = b;
    start = 1;
    tick;
    start = 0;
    chk({tag, "_imm0"}, 32'(imm), 32'(imm0_of(a)));
    n = 1;
    while (!done && n < 40) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, n, lat_of(a));
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_res"}, res, exp);
    tick;
    chk({tag, "_idle"}, {29'd0, busy, en, done}, 0);
    chk({tag, "_hold"}, res, exp);
  endtask

  initial begin
    int dones;
    tick;
    tick;
    chk("rst_ctl", {24'd0, imm, busy, en, done}, 0);
    chk("rst_res", res, 0);
    rst = 0;
    tick;
    // full sequence with explicit select stepping (default build)
`ifndef CM0_MUL_SEQ_EARLY_TERM_EN
    ra = 3;
    rb = 5;
    start = 1;
    tick;
    start = 0;
    for (int i = 1; i <= 32; i++) begin
      chk($sformatf("seq_imm%0d", i), 32'(imm), 32'(i % 32));
      chk($sformatf("seq_run%0d", i), {29'd0, busy, en, done}, 3'b110);
      tick;
    end
    chk("seq_done", {29'd0, busy, en, done}, 3'b101);
    chk("seq_res", res, 15);
    tick;
    chk("seq_idle", {29'd0, busy, en, done}, 0);
`endif
    do_mul("m3x5", 3, 5, 15);
    do_mul("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    do_mul("ovf", 32'h8000_0000, 2, 0);
    // kill in RUN cycle 10
    ra = 7;
    rb = 9;
    start = 1;
    tick;
    start = 0;
    repeat (9) tick;
    kill = 1;
    tick;
    kill = 0;
    chk("kill_ctl", {24'd0, imm, busy, en, done}, 0);
    dones = 0;
    repeat (35) begin
      tick;
      dones += int'(done);
    end
    chk("kill_nodone", dones, 0);
    do_mul("m2x21", 2, 21, 42);
    // start held through RUN is ignored
    ra = 3;
    rb = 5;
    start = 1;
    dones = 0;
    for (int i = 0; i < 40 && dones == 0; i++) begin
      tick;
      if (done) begin
        dones++;
        start = 0;
        chk("rep_res", res, 15);
      end
    end
    start = 0;
    repeat (40) begin
      tick;
      dones += int'(done);
    end
    chk("rep_once", dones, 1);
    // start and kill together in IDLE
    start = 1;
    kill = 1;
    tick;
    start = 0;
    kill = 0;
    chk("sk_idle", {29'd0, busy, en, done}, 0);
    tick;
    chk("sk_idle2", {29'd0, busy, en, done}, 0);
    // reset in RUN cycle 5
    ra = 7;
    rb = 9;
    start = 1;
    tick;
    start = 0;
    repeat (4) tick;
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1;
    tick;
    rst = 0;
    chk("mrst_ctl", {24'd0, imm, busy, en, done}, 0);
    chk("mrst_res", res, 0);
    do_mul("after_rst", 7, 9, 63);
`ifdef CM0_MUL_SEQ_EARLY_TERM_EN
    do_mul("et_one", 1, 32'h1234, 32'h1234);
    do_mul("et_zero", 0, 32'h1234, 0);
    do_mul("et_100", 32'h100, 3, 32'h300);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
